// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_e  : sequencer FSM states
//   NOP_INSTR      : addi x0,x0,0, loaded into IF/ID on flush/bubble
//   ADDR_WIDTH_DEF : default PC / instruction width
package fetch_pkg;
  localparam int          ADDR_WIDTH_DEF = 32;
  localparam logic [31:0] NOP_INSTR      = 32'h00000013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clr_i : synchronous clear (wins over enable)
//   en_i  : count enable
//   cnt_o : current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues one request at a time to instruction
// memory, steers the response into IF/ID, buffers it across load-use stalls
// and discards responses made stale by an Execute redirect.
//   clk, rst                  : clock, synchronous active-high reset
//   PCSrc_E, Stall_D          : redirect / load-use stall
//   PC_F                      : current PC
//   imem_req_*                : request channel (addr = PC_F)
//   imem_rvalid, imem_rdata   : response channel
//   Ins_F                     : instruction offered to IF/ID
//   PC_Write, IF_ID_Write     : register enables
//   Flush_D                   : load NOP into IF/ID
//   Bubble_cnt                : saturating count of bubble cycles
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc_E,
  input  logic                  Stall_D,
  input  logic [ADDR_WIDTH-1:0] PC_F,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rvalid,
  input  logic [ADDR_WIDTH-1:0] imem_rdata,
  output logic [ADDR_WIDTH-1:0] Ins_F,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  Flush_D,
  output logic [CNT_WIDTH-1:0]  Bubble_cnt
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] hold_q, hold_d;
  logic                  bubble;

  // PC_F is held by the PC register until PC_Write, so the address is
  // stable for as long as a request waits for ready.
  assign imem_req_addr = PC_F;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE:  state_d = S_ISSUE;
      S_ISSUE: if (!PCSrc_E && imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        // Without rvalid the request is still in flight: wait it out in DRAIN.
        if (PCSrc_E) state_d = imem_rvalid ? S_ISSUE : S_DRAIN;
        else if (imem_rvalid) begin
          if (Stall_D) begin
            state_d = S_HOLD;
            hold_d  = imem_rdata;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_HOLD:  if (PCSrc_E || !Stall_D) state_d = S_ISSUE;
      // A redirect here keeps us draining; the stale response is still owed.
      S_DRAIN: if (!PCSrc_E && imem_rvalid) state_d = S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    PC_Write       = 1'b0;
    IF_ID_Write    = 1'b0;
    Flush_D        = 1'b0;
    bubble         = 1'b0;
    Ins_F          = ADDR_WIDTH'(NOP_INSTR);
    case (state_q)
      S_ISSUE: imem_req_valid = !PCSrc_E;
      S_WAIT: if (imem_rvalid) begin
        Ins_F = imem_rdata;
        if (!PCSrc_E && !Stall_D) begin
          IF_ID_Write = 1'b1;
          PC_Write    = 1'b1;
        end
      end
      S_HOLD: begin
        Ins_F = hold_q;
        if (!PCSrc_E && !Stall_D) begin
          IF_ID_Write = 1'b1;
          PC_Write    = 1'b1;
        end
      end
      default: ;
    endcase
    // IDLE is the post-reset settle cycle: no flush, no bubble accounting.
    if (state_q != S_IDLE) begin
      if (PCSrc_E) begin
        PC_Write = 1'b1;
        Flush_D  = 1'b1;
      end else if (!Stall_D && !IF_ID_Write) begin
        Flush_D = 1'b1;
        bubble  = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (bubble),
    .cnt_o (Bubble_cnt)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, PCSrc_E, Stall_D, ready, rvalid;
  logic [31:0] PC_F, rdata, target;
  logic        req_valid, PC_Write, IF_ID_Write, Flush_D;
  logic [31:0] req_addr, Ins_F;
  logic [15:0] Bubble_cnt;

  fetch_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .PCSrc_E(PCSrc_E), .Stall_D(Stall_D), .PC_F(PC_F),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(ready),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .Ins_F(Ins_F),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .Flush_D(Flush_D),
    .Bubble_cnt(Bubble_cnt)
  );

  int errs = 0, checks = 0;

  // Reference model: tracks transactions, not FSM states.
  //   live: past the post-reset settle cycle; out: a request is in flight;
  //   drop: the in-flight response is stale; held: an instruction is parked.
  bit          m_live, m_out, m_drop, m_hold;
  logic [31:0] m_buf, pc;
  int unsigned m_cnt;
  bit          e_valid, e_ifw, e_pcw, e_fl, e_bub;
  logic [31:0] e_ins;
  bit          d_ifw;

  assign PC_F = pc;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_eval();
    e_valid = 0; e_ifw = 0; e_pcw = 0; e_fl = 0; e_bub = 0; e_ins = NOP;
    if (m_live) begin
      if (m_hold) e_ins = m_buf;
      else if (m_out && !m_drop && rvalid) e_ins = rdata;
      e_valid = !m_out && !m_hold && !PCSrc_E;
      if (PCSrc_E) begin
        e_pcw = 1; e_fl = 1;
      end else if (!Stall_D && (m_hold || (m_out && !m_drop && rvalid))) begin
        e_ifw = 1; e_pcw = 1;
      end
      e_bub = !PCSrc_E && !Stall_D && !e_ifw;
      if (e_bub) e_fl = 1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_live = 0; m_out = 0; m_drop = 0; m_hold = 0; m_buf = 0; m_cnt = 0; pc = 0;
    end else begin
      if (e_bub && m_cnt != 32'hFFFF) m_cnt++;
      if (e_pcw) pc = PCSrc_E ? target : pc + 4;
      if (!m_live) m_live = 1;
      else if (PCSrc_E) begin
        m_hold = 0;
        if (m_out && !m_drop) begin
          if (rvalid) m_out = 0; else m_drop = 1;
        end
      end else if (m_hold) begin
        if (!Stall_D) m_hold = 0;
      end else if (m_out) begin
        if (rvalid) begin
          if (!m_drop && Stall_D) begin m_hold = 1; m_buf = rdata; end
          m_out = 0; m_drop = 0;
        end
      end else if (e_valid && ready) m_out = 1;
    end
  endtask

  function automatic logic [95:0] dut_vec();
    return 96'({req_valid, req_addr, IF_ID_Write, PC_Write, Flush_D, Ins_F, Bubble_cnt});
  endfunction

  // Inputs are set by the caller one time unit after a rising edge.
  task automatic step(input bit do_chk);
    #1;
    model_eval();
    if (do_chk)
      chk("cycle", dut_vec(), 96'({e_valid, pc, e_ifw, e_pcw, e_fl, e_ins, m_cnt[15:0]}));
    d_ifw = IF_ID_Write;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    rst = 0; PCSrc_E = 0; Stall_D = 0; ready = 0; rvalid = 0; rdata = 0; target = 0;
  endtask

  typedef struct packed {
    logic        rst, pcsrc, stall, rdy, rv;
    logic [31:0] rd;
    logic        x_valid, x_ifw, x_pcw, x_fl;
    logic [31:0] x_ins;
    logic [15:0] x_cnt;
  } vec_t;
  vec_t vt[12];

  int          pulses;
  bit          pend;
  int unsigned dly;

  initial begin
    idle_in();
    pc = 0; m_live = 0; m_out = 0; m_drop = 0; m_hold = 0; m_buf = 0; m_cnt = 0;
    rst = 1;
    step(0);

    // rst pc st rdy rv rdata        | valid ifw pcw fl ins          cnt
    vt[0]  = '{1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, NOP,          16'd0};
    vt[1]  = '{0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, NOP,          16'd0};
    vt[2]  = '{0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 1, NOP,          16'd0};
    vt[3]  = '{0, 0, 0, 0, 1, 32'h11111111, 0, 1, 1, 0, 32'h11111111, 16'd1};
    vt[4]  = '{0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 1, NOP,          16'd1};
    vt[5]  = '{0, 0, 1, 0, 1, 32'h22222222, 0, 0, 0, 0, 32'h22222222, 16'd2};
    vt[6]  = '{0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h22222222, 16'd2};
    vt[7]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 0, 32'h22222222, 16'd2};
    vt[8]  = '{0, 1, 0, 1, 0, 32'h0,        0, 0, 1, 1, NOP,          16'd2};
    vt[9]  = '{0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 1, NOP,          16'd2};
    vt[10] = '{0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 1, NOP,          16'd3};
    vt[11] = '{0, 1, 0, 0, 1, 32'h33333333, 0, 0, 1, 1, 32'h33333333, 16'd4};
    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; PCSrc_E = vt[i].pcsrc; Stall_D = vt[i].stall;
      ready = vt[i].rdy; rvalid = vt[i].rv; rdata = vt[i].rd; target = 32'h200;
      #1;
      chk($sformatf("vec%0d", i),
          96'({req_valid, IF_ID_Write, PC_Write, Flush_D, Ins_F, Bubble_cnt}),
          96'({vt[i].x_valid, vt[i].x_ifw, vt[i].x_pcw, vt[i].x_fl, vt[i].x_ins, vt[i].x_cnt}));
      step(1);
    end

    // Load-use stall over three cycles while the response lands.
    idle_in(); rst = 1; step(1);
    rst = 0; step(1);
    ready = 1; step(1);
    ready = 0; rvalid = 1; rdata = 32'h00500093; Stall_D = 1;
    pulses = 0;
    step(1); pulses += int'(d_ifw);
    rvalid = 0; rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("hold_ins", 96'(Ins_F), 96'(32'h00500093));
      step(1); pulses += int'(d_ifw);
    end
    Stall_D = 0;
    #1 chk("hold_release_ins", 96'(Ins_F), 96'(32'h00500093));
    step(1); pulses += int'(d_ifw);
    step(1); pulses += int'(d_ifw);
    chk("hold_pulses", 96'(pulses), 96'(1));

    // Redirect while waiting; late response must be dropped.
    idle_in(); rst = 1; step(1);
    rst = 0; step(1);
    ready = 1; step(1);
    ready = 0; PCSrc_E = 1; target = 32'h00001000; step(1);
    PCSrc_E = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("drain_noreq", 96'(req_valid), 96'(0));
      step(1);
    end
    rvalid = 1; rdata = 32'hDEADBEEF;
    #1 chk("drain_discard", 96'({IF_ID_Write, PC_Write}), 96'(0));
    step(1);
    rvalid = 0;
    #1 chk("drain_target", 96'({req_valid, req_addr}), 96'({1'b1, 32'h00001000}));
    step(1);

    // Randomized traffic against the model.
    idle_in(); rst = 1; step(0); pend = 0; dly = 0;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom % 300) == 0;
      PCSrc_E = ($urandom % 8) == 0;
      Stall_D = ($urandom % 5) == 0;
      ready   = ($urandom % 3) != 0;
      rdata   = $urandom;
      target  = $urandom & 32'hFFFF_FFFC;
      if (pend) begin
        if (dly == 0) rvalid = 1;
        else begin rvalid = 0; dly--; end
      end else rvalid = ($urandom % 16) == 0;
      // A redirect coinciding with the drained response would strand DRAIN.
      if (rvalid && m_drop) PCSrc_E = 0;
      step(1);
      if (rst) pend = 0;
      else begin
        if (rvalid && pend) pend = 0;
        if (e_valid && ready) begin pend = 1; dly = $urandom_range(0, 3); end
      end
    end

    // Saturate the bubble counter, then reset for one cycle.
    idle_in(); rst = 1; step(0);
    rst = 0;
    for (int i = 0; i < 65536 + 6; i++) step(0);
    step(1);
    chk("sat", 96'(Bubble_cnt), 96'(16'hFFFF));
    rst = 1; step(0);
    rst = 0;
    #1 chk("reset_outs", 96'({req_valid, IF_ID_Write, PC_Write, Flush_D, Ins_F, Bubble_cnt}),
           96'({4'b0000, NOP, 16'h0000}));
    step(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: PC and instruction width.
REQ-002 Parameter CNT_WIDTH, default 16: bubble-counter width.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 PCSrc_E  in  1  redirect from Execute (taken branch or jump).
REQ-006 Stall_D  in  1  load-use stall from the hazard unit.
REQ-007 PC_F  in  ADDR_WIDTH  current PC-register value.
REQ-008 imem_req_valid / imem_req_addr  out  1 / ADDR_WIDTH  request channel; addr = PC_F.
REQ-009 imem_req_ready  in  1  memory accepts the request.
REQ-010 imem_rvalid / imem_rdata  in  1 / ADDR_WIDTH  response; one request outstanding at most.
REQ-011 Ins_F  out  ADDR_WIDTH  instruction offered to the IF/ID register.
REQ-012 PC_Write / IF_ID_Write  out  1 / 1  PC-register and IF/ID-register enables.
REQ-013 Flush_D  out  1  load NOP (32'h00000013) into IF/ID.
REQ-014 Bubble_cnt  out  CNT_WIDTH  saturating count of cycles in which Decode received a NOP bubble.

Function
REQ-015 States: IDLE, ISSUE, WAIT, HOLD, DRAIN; priority is rst > PCSrc_E > Stall_D > imem_rvalid.
REQ-016 IDLE: no request, one cycle after reset, then -> ISSUE.
REQ-017 ISSUE: imem_req_valid = !PCSrc_E; on valid&&ready -> WAIT; imem_req_addr stays stable while valid is high and not accepted.
REQ-018 WAIT, rvalid, no redirect, no stall: Ins_F = imem_rdata, IF_ID_Write=1, PC_Write=1, -> ISSUE.
REQ-019 WAIT, rvalid with Stall_D: capture imem_rdata into the hold buffer, PC_Write=0, IF_ID_Write=0, -> HOLD.
REQ-020 HOLD: Ins_F = buffer; when Stall_D drops, IF_ID_Write=1, PC_Write=1, -> ISSUE.
REQ-021 PCSrc_E in any state except IDLE: Flush_D=1, PC_Write=1, IF_ID_Write=0.
REQ-022 PCSrc_E next state: ISSUE -> ISSUE; WAIT without rvalid -> DRAIN; WAIT with rvalid -> ISSUE, response discarded; HOLD -> ISSUE, buffer discarded; DRAIN -> DRAIN.
REQ-023 DRAIN: no new request; on rvalid, discard data and -> ISSUE.
REQ-024 PC_Write=0 and IF_ID_Write=0 in every case not listed above.
REQ-025 Flush_D=1 also whenever Stall_D=0, PCSrc_E=0 and no instruction is delivered in that cycle (bubble).
REQ-026 Bubble_cnt increments by 1 on each bubble cycle from REQ-025 and saturates at all-ones without wrapping.
REQ-027 imem_rvalid outside WAIT/DRAIN is a protocol error and is ignored.

Reset
REQ-028 While rst=1, the next cycle shows: state=IDLE, hold buffer=0, Bubble_cnt=0, imem_req_valid=0, PC_Write=0, IF_ID_Write=0, Flush_D=0, Ins_F=32'h00000013.
REQ-029 Reset asserted mid-request abandons the outstanding request; the environment resets the memory on the same rst.

Structure
REQ-030 Shared package fetch_pkg holds the state enum, NOP_INSTR = 32'h00000013, and the default ADDR_WIDTH.
REQ-031 One sub-module, sat_counter (parameter width, enable, synchronous clear), implements Bubble_cnt.
REQ-032 Next-state logic and output decode are combinational; only state, the hold buffer and the counter are registered.

Verification
REQ-033 Zero-wait memory (ready=1, rvalid one cycle after accept), no hazards -> one instruction every 2 cycles, Bubble_cnt increments on each ISSUE cycle.
REQ-034 Stall_D=1 for 3 cycles coinciding with rvalid, rdata=32'h00500093 -> HOLD; Ins_F holds 32'h00500093; IF_ID_Write pulses once when the stall drops.
REQ-035 PCSrc_E in WAIT, rvalid 4 cycles later -> DRAIN; that response is discarded; the next request address equals the loaded target.
REQ-036 PCSrc_E together with rvalid in WAIT -> Flush_D=1, PC_Write=1, the response is never written to IF/ID, next state ISSUE.
REQ-037 Force 2^16+5 bubble cycles -> Bubble_cnt = 16'hFFFF; rst=1 for one cycle -> all outputs match REQ-028.
